computer12_bus_fabric: RTL and testbench
========================================

# computer12_bus_fabric

Memory/IO fabric of the Computer12 system, sitting between the Processor12 CPU bus and its memories and peripherals. It contains:
- the reset synchronizer;
- the address decoder with registered region selects;
- the 32K×12 program RAM (pmem);
- the read-data multiplexer;
- the video-RAM CPU port, keyboard register and interrupt vector wiring.

All logic is clocked by the PLL output clock.

## Interface

Parameters:
- PMEM_BASE, 24'o00004000: first pmem address (inclusive).
- VMEM_BASE, 24'o00100000: first vmem address; also the end of pmem (exclusive).
- VMEM_END, 24'o00140000: end of vmem (exclusive).
- KBD_ADDR, 24'o00003000: keyboard scancode register address.

Ports:
- clk  in  1  system clock.
- rst_async  in  1  reset, asynchronous, active-low.
- rst  out  1  synchronized active-low reset to the CPU.
- cpu_addr  in  24  CPU word address.
- cpu_wdata  in  12  CPU write data.
- cpu_write  in  1  CPU write strobe.
- cpu_rdata  out  12  read data to CPU.
- irq  out  24  interrupt request vector.
- vmem_addr  out  14  video-RAM port address.
- vmem_wdata  out  12  video-RAM port write data.
- vmem_we  out  1  video-RAM port write enable.
- vmem_rdata  in  12  video-RAM port registered read data.
- kbd_scancode  in  8  last PS/2 scancode.
- kbd_new  in  1  new-scancode pulse.
- blinkenlights  out  8  debug LEDs.

## Operation

Reset synchronizer:
- Two-flop shift register {rst, s1}.
- While rst_async=0, both flops clear asynchronously.
- Otherwise each clk rising edge does {rst, s1} <= {s1, 1}.

Decode (combinational on cpu_addr, unsigned compares):
- pmem_hit = PMEM_BASE ≤ addr < VMEM_BASE.
- vmem_hit = VMEM_BASE ≤ addr < VMEM_END.
- kbd_hit = addr == KBD_ADDR.
- The regions are disjoint.

Registered selects:
- pmem_active, vmem_active and kbd_active load pmem_hit, vmem_hit and kbd_hit every clk edge.
- All three clear asynchronously on rst_async=0.

Program RAM:
- 32768×12 single-port synchronous RAM, initialized to 0.
- Address is cpu_addr[14:0].
- Write enable is cpu_write & pmem_active, so writes are gated by the registered (previous-cycle) select.
- Read data is registered with one-cycle latency.
- Read-during-write to the same address returns the old data.

Video port:
- vmem_addr = cpu_addr[13:0].
- vmem_wdata = cpu_wdata.
- vmem_we = cpu_write & vmem_active.

Read mux (combinational, priority order):
- pmem_active: pmem q.
- else vmem_active: vmem_rdata.
- else kbd_active: {4'b0, kbd_scancode}.
- else 12'o0000.

Other outputs:
- irq[0] = kbd_new; irq[23:1] = 0.
- blinkenlights = cpu_addr[7:0], combinational.
- Addresses outside all regions read 0; writes to them are discarded.
- Keyboard writes are ignored.

## Timing

- rst is 0 during reset, and for one more edge after release.
- rst goes 1 on the second clk rising edge after rst_async deasserts.
- A mid-operation rst_async low forces rst=0 and all selects=0 immediately, without waiting for a clock. pmem contents are preserved.
- Read latency is one clock: the address presented in cycle N gives valid cpu_rdata in cycle N+1 for pmem, vmem and kbd.
- The kbd value is sampled combinationally in cycle N+1.
- Write timing: a write is performed at edge N+1 using cycle-N+1 address/data, provided the address in cycle N decoded to the same region. Stable address across two cycles guarantees the write lands.
- Reset values:
  - rst = 0; selects = 0; cpu_rdata = 0.
  - irq follows kbd_new.
  - vmem_we = 0.

## Test plan

- Reset: hold rst_async=0, then release it → rst=0 after edge 1 and rst=1 after edge 2. Pulse rst_async low mid-run → rst=0 asynchronously.
- pmem write/read: addr 24'o00004000, wdata 12'o1234, write=1 held 2 cycles, then read the same address → cpu_rdata=12'o1234 one cycle later. Also address 24'o00077777 ↔ 12'o7777.
- Region bounds:
  - 24'o00003777 reads 0 and writes have no effect.
  - 24'o00100000 returns vmem_rdata (drive 12'o5555).
  - 24'o00137777 is vmem.
  - 24'o00140000 reads 0 with vmem_we=0.
- Keyboard: kbd_scancode=8'h1C, addr 24'o00003000 → next cycle cpu_rdata=12'h01C. A kbd_new pulse appears on irq[0] the same cycle, with irq[23:1]=0.
- Region switch: a write to vmem immediately after a pmem access → the first cycle's write is not performed (vmem_we=0 on that cycle), and the next cycle's write is performed (vmem_we=1).
- Debug LEDs: addr 24'o00004321 → blinkenlights=8'hD1.

Source files
------------

// File: rtl/computer12_bus_fabric.sv
// Computer12 memory/IO fabric: reset synchronizer, region decode with registered
// selects, 32K x 12 program RAM, read mux and the video/keyboard/irq wiring.
module computer12_bus_fabric #(
    parameter logic [23:0] PMEM_BASE = 24'o00004000,
    parameter logic [23:0] VMEM_BASE = 24'o00100000,
    parameter logic [23:0] VMEM_END  = 24'o00140000,
    parameter logic [23:0] KBD_ADDR  = 24'o00003000
) (
    input  logic        clk,
    input  logic        rst_async,
    output logic        rst,
    input  logic [23:0] cpu_addr,
    input  logic [11:0] cpu_wdata,
    input  logic        cpu_write,
    output logic [11:0] cpu_rdata,
    output logic [23:0] irq,
    output logic [13:0] vmem_addr,
    output logic [11:0] vmem_wdata,
    output logic        vmem_we,
    input  logic [11:0] vmem_rdata,
    input  logic [7:0]  kbd_scancode,
    input  logic        kbd_new,
    output logic [7:0]  blinkenlights
);

    logic        rst_s1;
    logic        pmem_hit;
    logic        vmem_hit;
    logic        kbd_hit;
    logic        pmem_active;
    logic        vmem_active;
    logic        kbd_active;
    logic        pmem_we;
    logic [11:0] pmem_q;
    logic [11:0] pmem [0:32767];

    // Assertion is asynchronous; release reaches rst on the second edge.
    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            rst_s1 <= 1'b0;
            rst    <= 1'b0;
        end else begin
            rst_s1 <= 1'b1;
            rst    <= rst_s1;
        end
    end

    assign pmem_hit = (cpu_addr >= PMEM_BASE) && (cpu_addr < VMEM_BASE);
    assign vmem_hit = (cpu_addr >= VMEM_BASE) && (cpu_addr < VMEM_END);
    assign kbd_hit  = (cpu_addr == KBD_ADDR);

    // Selects describe the previous cycle's address; they steer read data
    // returned this cycle and gate this cycle's writes.
    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            pmem_active <= 1'b0;
            vmem_active <= 1'b0;
            kbd_active  <= 1'b0;
        end else begin
            pmem_active <= pmem_hit;
            vmem_active <= vmem_hit;
            kbd_active  <= kbd_hit;
        end
    end

    assign pmem_we = cpu_write & pmem_active;

    // Nonblocking read and write on the same edge yields old-data read-during-write.
    always_ff @(posedge clk) begin
        if (pmem_we) begin
            pmem[cpu_addr[14:0]] <= cpu_wdata;
        end
        pmem_q <= pmem[cpu_addr[14:0]];
    end

    always_comb begin
        cpu_rdata = 12'o0000;
        if (pmem_active) begin
            cpu_rdata = pmem_q;
        end else if (vmem_active) begin
            cpu_rdata = vmem_rdata;
        end else if (kbd_active) begin
            cpu_rdata = {4'b0000, kbd_scancode};
        end
    end

    assign vmem_addr     = cpu_addr[13:0];
    assign vmem_wdata    = cpu_wdata;
    assign vmem_we       = cpu_write & vmem_active;
    assign irq           = {23'b0, kbd_new};
    assign blinkenlights = cpu_addr[7:0];

endmodule

// File: tb/tb_computer12_bus_fabric.sv
// Randomized and directed bench for computer12_bus_fabric against a region-level
// reference model (memory map, one-cycle read latency, previous-cycle write gating).
module tb_computer12_bus_fabric;

    localparam int R_NONE = 0;
    localparam int R_PMEM = 1;
    localparam int R_VMEM = 2;
    localparam int R_KBD  = 3;

    logic        clk = 1'b0;
    logic        rst_async;
    logic        rst;
    logic [23:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic        cpu_write;
    logic [11:0] cpu_rdata;
    logic [23:0] irq;
    logic [13:0] vmem_addr;
    logic [11:0] vmem_wdata;
    logic        vmem_we;
    logic [11:0] vmem_rdata;
    logic [7:0]  kbd_scancode;
    logic        kbd_new;
    logic [7:0]  blinkenlights;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [11:0] mem_model [int];
    int          prev_region;
    logic [11:0] rd_snap;
    bit          rd_known;
    int          sync_cnt;

    always #5 clk = ~clk;

    computer12_bus_fabric dut (
        .clk          (clk),
        .rst_async    (rst_async),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_write    (cpu_write),
        .cpu_rdata    (cpu_rdata),
        .irq          (irq),
        .vmem_addr    (vmem_addr),
        .vmem_wdata   (vmem_wdata),
        .vmem_we      (vmem_we),
        .vmem_rdata   (vmem_rdata),
        .kbd_scancode (kbd_scancode),
        .kbd_new      (kbd_new),
        .blinkenlights(blinkenlights)
    );

    function automatic int region_of(input logic [23:0] a);
        if (a >= 24'o00004000 && a < 24'o00100000) return R_PMEM;
        if (a >= 24'o00100000 && a < 24'o00140000) return R_VMEM;
        if (a == 24'o00003000) return R_KBD;
        return R_NONE;
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic verify();
        logic [11:0] exp_rd;
        bit          rd_valid;
        rd_valid = 1'b1;
        case (prev_region)
            R_PMEM:  begin exp_rd = rd_snap; rd_valid = rd_known; end
            R_VMEM:  exp_rd = vmem_rdata;
            R_KBD:   exp_rd = {4'b0000, kbd_scancode};
            default: exp_rd = 12'o0000;
        endcase
        if (rd_valid) check("cpu_rdata", {12'b0, cpu_rdata}, {12'b0, exp_rd});
        check("rst", {23'b0, rst}, {23'b0, (sync_cnt >= 2)});
        check("vmem_we", {23'b0, vmem_we},
              {23'b0, (cpu_write && prev_region == R_VMEM)});
        check("vmem_addr", {10'b0, vmem_addr}, {10'b0, cpu_addr[13:0]});
        check("vmem_wdata", {12'b0, vmem_wdata}, {12'b0, cpu_wdata});
        check("irq", irq, {23'b0, kbd_new});
        check("blinken", {16'b0, blinkenlights}, {16'b0, cpu_addr[7:0]});
    endtask

    // One bus cycle: advance the model across the edge, drive new inputs, check mid-cycle.
    task automatic step(input logic [23:0] a, input logic [11:0] wd, input logic w,
                        input logic [11:0] vrd, input logic [7:0] ks, input logic kn);
        int idx;
        @(posedge clk);
        if (!rst_async) begin
            prev_region = R_NONE;
            sync_cnt    = 0;
            rd_known    = 1'b0;
        end else begin
            idx      = int'(cpu_addr[14:0]);
            rd_known = mem_model.exists(idx);
            rd_snap  = rd_known ? mem_model[idx] : 12'o0000;
            if (cpu_write && prev_region == R_PMEM) mem_model[idx] = cpu_wdata;
            prev_region = region_of(cpu_addr);
            if (sync_cnt < 2) sync_cnt++;
        end
        #1;
        cpu_addr     = a;
        cpu_wdata    = wd;
        cpu_write    = w;
        vmem_rdata   = vrd;
        kbd_scancode = ks;
        kbd_new      = kn;
        @(negedge clk);
        verify();
    endtask

    initial begin
        logic [23:0] pool [8];
        logic [23:0] a;
        rst_async    = 1'b0;
        cpu_addr     = 24'o0;
        cpu_wdata    = 12'o0;
        cpu_write    = 1'b0;
        vmem_rdata   = 12'o0;
        kbd_scancode = 8'h00;
        kbd_new      = 1'b0;
        prev_region  = R_NONE;
        sync_cnt     = 0;
        rd_known     = 1'b0;
        rd_snap      = 12'o0;
        #2;
        check("reset_rst", {23'b0, rst}, 24'd0);
        check("reset_rdata", {12'b0, cpu_rdata}, 24'd0);
        check("reset_vmem_we", {23'b0, vmem_we}, 24'd0);

        // Reset held, then released between edges
        step(24'o00003000, 12'o0, 1'b0, 12'o0, 8'h55, 1'b1);
        step(24'o00100000, 12'o0, 1'b1, 12'o0, 8'h55, 1'b0);
        rst_async = 1'b1;
        step(24'o00000000, 12'o0, 1'b0, 12'o0, 8'h00, 1'b0);
        check("rst_edge1", {23'b0, rst}, 24'd0);
        step(24'o00000000, 12'o0, 1'b0, 12'o0, 8'h00, 1'b0);
        check("rst_edge2", {23'b0, rst}, 24'd1);

        // Program RAM at both ends of its region
        step(24'o00004000, 12'o1234, 1'b1, 12'o0, 8'h00, 1'b0);
        step(24'o00004000, 12'o1234, 1'b1, 12'o0, 8'h00, 1'b0);
        step(24'o00004000, 12'o0000, 1'b0, 12'o0, 8'h00, 1'b0);
        step(24'o00004000, 12'o0000, 1'b0, 12'o0, 8'h00, 1'b0);
        check("pmem_4000", {12'b0, cpu_rdata}, {12'b0, 12'o1234});
        step(24'o00077777, 12'o7777, 1'b1, 12'o0, 8'h00, 1'b0);
        step(24'o00077777, 12'o7777, 1'b1, 12'o0, 8'h00, 1'b0);
        step(24'o00077777, 12'o0000, 1'b0, 12'o0, 8'h00, 1'b0);
        step(24'o00077777, 12'o0000, 1'b0, 12'o0, 8'h00, 1'b0);
        check("pmem_77777", {12'b0, cpu_rdata}, {12'b0, 12'o7777});

        // Region boundaries
        step(24'o00003777, 12'o1111, 1'b1, 12'o4444, 8'h00, 1'b0);
        step(24'o00003777, 12'o1111, 1'b1, 12'o4444, 8'h00, 1'b0);
        step(24'o00003777, 12'o0000, 1'b0, 12'o4444, 8'h00, 1'b0);
        check("below_pmem", {12'b0, cpu_rdata}, 24'd0);
        step(24'o00100000, 12'o0000, 1'b0, 12'o5555, 8'h00, 1'b0);
        step(24'o00100000, 12'o0000, 1'b0, 12'o5555, 8'h00, 1'b0);
        check("vmem_base", {12'b0, cpu_rdata}, {12'b0, 12'o5555});
        step(24'o00137777, 12'o3210, 1'b1, 12'o1212, 8'h00, 1'b0);
        step(24'o00137777, 12'o3210, 1'b1, 12'o1212, 8'h00, 1'b0);
        check("vmem_top_we", {23'b0, vmem_we}, 24'd1);
        check("vmem_top_rd", {12'b0, cpu_rdata}, {12'b0, 12'o1212});
        step(24'o00140000, 12'o3210, 1'b1, 12'o1212, 8'h00, 1'b0);
        step(24'o00140000, 12'o3210, 1'b1, 12'o1212, 8'h00, 1'b0);
        check("vmem_end_rd", {12'b0, cpu_rdata}, 24'd0);
        check("vmem_end_we", {23'b0, vmem_we}, 24'd0);

        // Keyboard and interrupt
        step(24'o00003000, 12'o0000, 1'b0, 12'o0, 8'h1C, 1'b0);
        step(24'o00003000, 12'o0000, 1'b0, 12'o0, 8'h1C, 1'b1);
        check("kbd_rd", {12'b0, cpu_rdata}, 24'h00001C);
        check("kbd_irq", irq, 24'h000001);

        // Region switch: the first vmem write cycle is gated off
        step(24'o00004010, 12'o0000, 1'b1, 12'o0, 8'h00, 1'b0);
        step(24'o00100005, 12'o2222, 1'b1, 12'o0, 8'h00, 1'b0);
        check("switch_we0", {23'b0, vmem_we}, 24'd0);
        step(24'o00100005, 12'o2222, 1'b1, 12'o0, 8'h00, 1'b0);
        check("switch_we1", {23'b0, vmem_we}, 24'd1);

        step(24'o00004321, 12'o0000, 1'b0, 12'o0, 8'h00, 1'b0);
        check("leds", {16'b0, blinkenlights}, 24'h0000D1);

        // Mid-run asynchronous reset while selecting the keyboard
        step(24'o00003000, 12'o0000, 1'b1, 12'o0, 8'hA5, 1'b0);
        step(24'o00003000, 12'o0000, 1'b1, 12'o0, 8'hA5, 1'b0);
        check("pre_async_rd", {12'b0, cpu_rdata}, 24'h0000A5);
        #1;
        rst_async   = 1'b0;
        prev_region = R_NONE;
        sync_cnt    = 0;
        #1;
        check("async_rst", {23'b0, rst}, 24'd0);
        check("async_rdata", {12'b0, cpu_rdata}, 24'd0);
        step(24'o00004000, 12'o0000, 1'b0, 12'o0, 8'h00, 1'b0);
        rst_async = 1'b1;
        step(24'o00004000, 12'o0000, 1'b0, 12'o0, 8'h00, 1'b0);
        step(24'o00004000, 12'o0000, 1'b0, 12'o0, 8'h00, 1'b0);
        check("pmem_kept", {12'b0, cpu_rdata}, {12'b0, 12'o1234});

        // Randomized traffic over a pool of pmem words plus the other regions
        for (int i = 0; i < 8; i++) begin
            pool[i] = 24'o00004000 + 24'($urandom_range(0, 24'o00073777));
            step(pool[i], 12'($urandom), 1'b1, 12'o0, 8'h00, 1'b0);
            step(pool[i], 12'($urandom), 1'b1, 12'o0, 8'h00, 1'b0);
        end
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = pool[$urandom_range(0, 7)];
                2:       a = 24'o00100000 + 24'($urandom_range(0, 24'o00037777));
                3:       a = 24'o00003000;
                4:       a = 24'($urandom_range(0, 24'o00003777));
                default: a = 24'o00140000 + 24'($urandom_range(0, 24'o00077777));
            endcase
            repeat ($urandom_range(1, 2))
                step(a, 12'($urandom), 1'($urandom), 12'($urandom),
                     8'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
